// File: rtl/speed_round_ctrl.sv
// -----------------------------------------------------------------------------
// speed_round_ctrl
//
// Sequencer for the speed-round push counter. A round runs through these
// steps:
//   1. A clear pulse resets stale push counts.
//   2. A pre-round countdown runs for PRE_TICKS game ticks.
//   3. The counting window (speed_round) stays open for ROUND_TICKS ticks.
//   4. Two settle cycles let the counter's registered compare catch up.
//   5. The winner is judged.
//   6. A second clear pulse is issued, and the result is held.
//
// Ports
//   clk, rst          system clock, synchronous active-high reset
//   tick              one-cycle game time-base enable
//   start             round request (level, accepted only in IDLE/DONE)
//   abort             cancel round (honoured in CLEAR/COUNTDOWN/ACTIVE/SETTLE)
//   speed_tie         push counter: counts equal (registered)
//   speed_right       push counter: right count greater (registered)
//   speed_round       counting-window enable to the push counter
//   speed_exit        one-cycle clear pulse to the push counter
//   countdown         remaining pre-round ticks, for the display
//   time_left         remaining window ticks, for the display
//   busy              high in every state except IDLE and DONE
//   result_valid      winner is valid
//   winner            00 none, 01 left, 10 right, 11 tie
//   dbg_state         current FSM state encoding, for observation only
//
// Handshake: result_valid/winner form a level-valid output with no ready.
// Once result_valid rises in DONE, winner is stable until the next accepted
// start or rst. No consumer acknowledgement is required.
// -----------------------------------------------------------------------------
module speed_round_ctrl #(
  parameter int PRE_TICKS   = 3,
  parameter int ROUND_TICKS = 50,
  parameter int TW          = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          tick,
  input  logic          start,
  input  logic          abort,
  input  logic          speed_tie,
  input  logic          speed_right,
  output logic          speed_round,
  output logic          speed_exit,
  output logic [3:0]    countdown,
  output logic [TW-1:0] time_left,
  output logic          busy,
  output logic          result_valid,
  output logic [1:0]    winner,
  output logic [2:0]    dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_CLEAR     = 3'd1,
    S_COUNTDOWN = 3'd2,
    S_ACTIVE    = 3'd3,
    S_SETTLE    = 3'd4,
    S_JUDGE     = 3'd5,
    S_EXIT      = 3'd6,
    S_DONE      = 3'd7
  } state_t;

  localparam logic [3:0]    PRE_LD = 4'(PRE_TICKS);
  localparam logic [TW-1:0] RT_LD  = TW'(ROUND_TICKS);

  state_t        r_state;
  logic          r_speed_round;
  logic          r_speed_exit;
  logic [3:0]    r_countdown;
  logic [TW-1:0] r_time_left;
  logic          r_busy;
  logic          r_result_valid;
  logic [1:0]    r_winner;
  logic          r_settle_cnt;   // counts the two SETTLE cycles
  logic          r_aborted;      // EXIT returns to IDLE instead of DONE

  logic w_abortable;
  assign w_abortable = (r_state == S_CLEAR) || (r_state == S_COUNTDOWN) ||
                       (r_state == S_ACTIVE) || (r_state == S_SETTLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_speed_round  <= 1'b0;
      r_speed_exit   <= 1'b0;
      r_countdown    <= 4'd0;
      r_time_left    <= '0;
      r_busy         <= 1'b0;
      r_result_valid <= 1'b0;
      r_winner       <= 2'b00;
      r_settle_cnt   <= 1'b0;
      r_aborted      <= 1'b0;
    end else begin
      // speed_exit is a single-cycle pulse; only entry to CLEAR/EXIT raises it.
      r_speed_exit <= 1'b0;

      if (abort && w_abortable) begin
        r_state        <= S_EXIT;
        r_speed_exit   <= 1'b1;
        r_speed_round  <= 1'b0;
        r_countdown    <= 4'd0;
        r_time_left    <= '0;
        r_winner       <= 2'b00;
        r_result_valid <= 1'b0;
        r_aborted      <= 1'b1;
      end else begin
        case (r_state)
          S_IDLE, S_DONE: begin
            if (start) begin
              r_state        <= S_CLEAR;
              r_speed_exit   <= 1'b1;
              r_result_valid <= 1'b0;
              r_winner       <= 2'b00;
              r_busy         <= 1'b1;
              r_countdown    <= PRE_LD;
              r_time_left    <= '0;
              r_aborted      <= 1'b0;
            end
          end
          // Ticks arriving during CLEAR are deliberately not counted.
          S_CLEAR: r_state <= S_COUNTDOWN;
          S_COUNTDOWN: begin
            if (tick) begin
              if (r_countdown <= 4'd1) begin
                r_state       <= S_ACTIVE;
                r_countdown   <= 4'd0;
                r_time_left   <= RT_LD;
                r_speed_round <= 1'b1;
              end else begin
                r_countdown <= r_countdown - 4'd1;
              end
            end
          end
          S_ACTIVE: begin
            if (tick) begin
              if (r_time_left <= TW'(1)) begin
                r_state       <= S_SETTLE;
                r_time_left   <= '0;
                r_speed_round <= 1'b0;
                r_settle_cnt  <= 1'b0;
              end else begin
                r_time_left <= r_time_left - TW'(1);
              end
            end
          end
          // Two idle cycles: the last counter increment, then its compare register.
          S_SETTLE: begin
            if (r_settle_cnt) r_state <= S_JUDGE;
            else              r_settle_cnt <= 1'b1;
          end
          S_JUDGE: begin
            // Tie wins over right if the counter ever reports both.
            if (speed_tie)        r_winner <= 2'b11;
            else if (speed_right) r_winner <= 2'b10;
            else                  r_winner <= 2'b01;
            r_state      <= S_EXIT;
            r_speed_exit <= 1'b1;
          end
          S_EXIT: begin
            r_busy <= 1'b0;
            if (r_aborted) begin
              r_state <= S_IDLE;
            end else begin
              r_state        <= S_DONE;
              r_result_valid <= 1'b1;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign speed_round  = r_speed_round;
  assign speed_exit   = r_speed_exit;
  assign countdown    = r_countdown;
  assign time_left    = r_time_left;
  assign busy         = r_busy;
  assign result_valid = r_result_valid;
  assign winner       = r_winner;
  assign dbg_state    = r_state;

endmodule

// File: tb/tb_speed_round_ctrl.sv
// -----------------------------------------------------------------------------
// tb_speed_round_ctrl
//
// Table of rounds (compare inputs, abort point, expected result) applied in a
// loop, plus hand-written sequences for abort-in-CLEAR, abort/start in DONE,
// result hold and reset during SETTLE. The expected {result_valid, winner}
// is queued when each round is started and popped when its EXIT pulse
// completes.
// -----------------------------------------------------------------------------
module tb_speed_round_ctrl;
  localparam int PRE = 3;
  localparam int RT  = 5;
  localparam int TW  = 8;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          tick = 1'b0, start = 1'b0, abort = 1'b0;
  logic          speed_tie = 1'b0, speed_right = 1'b0;
  logic          speed_round, speed_exit, busy, result_valid;
  logic [3:0]    countdown;
  logic [TW-1:0] time_left;
  logic [1:0]    winner;
  logic [2:0]    dbg_state;

  speed_round_ctrl #(.PRE_TICKS(PRE), .ROUND_TICKS(RT), .TW(TW)) dut (
    .clk(clk), .rst(rst), .tick(tick), .start(start), .abort(abort),
    .speed_tie(speed_tie), .speed_right(speed_right),
    .speed_round(speed_round), .speed_exit(speed_exit),
    .countdown(countdown), .time_left(time_left), .busy(busy),
    .result_valid(result_valid), .winner(winner), .dbg_state(dbg_state)
  );

  // scoreboard
  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  logic [2:0] exp_q[$];

  typedef struct {
    bit         tie;
    bit         right;
    int         abort_n;     // abort on this ACTIVE tick, 0 = never
    bit         mid_start;   // pulse start during ACTIVE
    logic [2:0] exp_res;     // {result_valid, winner}
  } rec_t;

  rec_t tbl[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Advance to the next negedge, schedule tick for the coming posedge,
  // and check the always-true output relations.
  task automatic cycle();
    @(negedge clk);
    cyc++;
    tick = (cyc % 4 == 0);
    check("excl_exit_round", speed_exit & speed_round, 0);
    check("round_needs_busy", speed_round & ~busy, 0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_round"}, speed_round, 0);
    check({tag, "_exit"}, speed_exit, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_rv"}, result_valid, 0);
    check({tag, "_cd"}, countdown, 0);
    check({tag, "_tl"}, time_left, 0);
    check({tag, "_win"}, winner, 0);
    check({tag, "_state"}, dbg_state, 0);
  endtask

  task automatic run_round(input rec_t r);
    int active_ticks = 0;
    int settle_cnt = 0;
    int budget = 0;
    bit saw_active = 1'b0;
    bit done = 1'b0;
    logic [3:0] cd_q[$];
    logic [TW-1:0] tl_q[$];
    logic [2:0] exp_v;
    speed_tie   = r.tie;
    speed_right = r.right;
    exp_q.push_back(r.exp_res);
    start = 1'b1;
    cycle();
    start = 1'b0;
    check("clear_exit", speed_exit, 1);
    check("clear_cd", countdown, PRE);
    check("clear_busy", busy, 1);
    check("clear_rv", result_valid, 0);
    check("clear_win", winner, 0);
    check("clear_state", dbg_state, 1);
    cd_q.push_back(countdown);
    tl_q.push_back(time_left);
    cycle();
    while (!done && budget < 1000) begin
      budget++;
      if (countdown != cd_q[$]) cd_q.push_back(countdown);
      if (time_left != tl_q[$]) tl_q.push_back(time_left);
      if (speed_round) saw_active = 1'b1;
      if (speed_exit) begin
        cycle();
        exp_v = exp_q.pop_front();
        check("result", {result_valid, winner}, exp_v);
        check("end_busy", busy, 0);
        check("end_exit_width", speed_exit, 0);
        check("end_state", dbg_state, (r.abort_n > 0) ? 0 : 7);
        done = 1'b1;
      end else begin
        if (saw_active && !speed_round && busy) settle_cnt++;
        if (speed_round && tick) begin
          active_ticks++;
          if (r.abort_n == active_ticks) abort = 1'b1;
          if (r.mid_start && active_ticks == 2) start = 1'b1;
        end
        cycle();
        abort = 1'b0;
        start = 1'b0;
      end
    end
    check("round_done", done, 1);
    check("active_ticks", active_ticks, (r.abort_n > 0) ? r.abort_n : RT);
    check("settle_cycles", settle_cnt, (r.abort_n > 0) ? 0 : 3);
    check("cd_len", cd_q.size(), PRE + 1);
    for (int i = 0; i < cd_q.size() && i <= PRE; i++)
      check("cd_seq", cd_q[i], PRE - i);
    if (r.abort_n == 0) begin
      check("tl_len", tl_q.size(), RT + 2);
      check("tl_first", tl_q[0], 0);
      for (int i = 1; i < tl_q.size() && i <= RT + 1; i++)
        check("tl_seq", tl_q[i], RT - (i - 1));
    end
  endtask

  initial begin
    int seen;
    int budget;
    bit t;
    bit rr;

    tbl[0] = '{1'b0, 1'b1, 0, 1'b0, 3'b110};
    tbl[1] = '{1'b1, 1'b1, 0, 1'b0, 3'b111};
    tbl[2] = '{1'b0, 1'b0, 0, 1'b0, 3'b101};
    tbl[3] = '{1'b0, 1'b1, 3, 1'b0, 3'b000};
    tbl[4] = '{1'b1, 1'b0, 0, 1'b1, 3'b111};
    for (int k = 5; k < 7; k++) begin
      t  = 1'($urandom_range(0, 1));
      rr = 1'($urandom_range(0, 1));
      tbl[k] = '{t, rr, 0, 1'b0, t ? 3'b111 : (rr ? 3'b110 : 3'b101)};
    end
    tbl[7] = '{1'b0, 1'b1, 0, 1'b0, 3'b110};

    rst = 1'b1;
    repeat (3) cycle();
    check_reset_vals("reset");
    rst = 1'b0;
    cycle();

    for (int k = 0; k < 8; k++) run_round(tbl[k]);

    // result holds in DONE
    for (int i = 0; i < 100; i++) begin
      cycle();
      check("hold_result", {result_valid, winner}, tbl[7].exp_res);
      check("hold_busy", busy, 0);
    end

    // abort in DONE ignored
    abort = 1'b1;
    cycle();
    abort = 1'b0;
    check("abort_done_state", dbg_state, 7);
    check("abort_done_exit", speed_exit, 0);
    check("abort_done_rv", result_valid, 1);

    // abort together with start in DONE: start wins
    abort = 1'b1;
    start = 1'b1;
    cycle();
    start = 1'b0;
    check("abst_state", dbg_state, 1);
    check("abst_exit", speed_exit, 1);
    check("abst_cd", countdown, PRE);
    check("abst_rv", result_valid, 0);
    // abort still high in CLEAR -> EXIT -> IDLE
    cycle();
    abort = 1'b0;
    check("abclr_state", dbg_state, 6);
    check("abclr_exit", speed_exit, 1);
    check("abclr_cd", countdown, 0);
    cycle();
    check_reset_vals("abclr_idle");

    // rst during SETTLE
    speed_tie = 1'b0;
    speed_right = 1'b1;
    start = 1'b1;
    cycle();
    start = 1'b0;
    seen = 0;
    budget = 0;
    while (!(seen != 0 && !speed_round) && budget < 500) begin
      if (speed_round) seen = 1;
      cycle();
      budget++;
    end
    check("reach_settle", dbg_state, 4);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check_reset_vals("rst_settle");
    for (int i = 0; i < 6; i++) begin
      cycle();
      check("no_exit_after_rst", speed_exit, 0);
      check("idle_after_rst", busy, 0);
    end

    // recovery round after reset
    run_round(tbl[2]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
